// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU ops, control bit
// positions, immediate formats and the decode->execute payload.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  // ex_ctrl = {reg_write, mem_read, mem_write, branch, jal, jalr, use_imm, use_pc}
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JAL       = 3;
  localparam int CTRL_JALR      = 2;
  localparam int CTRL_USE_IMM   = 1;
  localparam int CTRL_USE_PC    = 0;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_fmt_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] insn, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   gen_imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   gen_imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   gen_imm = {insn[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      IMM_SH:  gen_imm = {27'b0, insn[24:20]};
      default: gen_imm = {{20{insn[31]}}, insn[31:20]};
    endcase
  endfunction

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic [7:0]  ctrl;
    logic        illegal;
  } ex_t;

endpackage

// File: rtl/decode_if.sv
// Decode stage bus: fetch/writeback inputs and the registered execute payload.
interface decode_if;
  import rv32i_pkg::*;

  logic [31:0] insn;
  logic [31:0] pc_de;
  logic        pc_ex_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  alu_op_t     ex_alu_op;
  logic [7:0]  ex_ctrl;
  logic        ex_illegal;

  modport master (
    output insn, pc_de, pc_ex_valid, wb_en, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
           ex_funct3, ex_alu_op, ex_ctrl, ex_illegal
  );

  modport slave (
    input  insn, pc_de, pc_ex_valid, wb_en, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
           ex_funct3, ex_alu_op, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// 32x32 register file, 2 combinational reads, 1 write; x0 reads zero.
// DECODE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module decode_regfile (
  input  logic        clk,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val
);
  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (wb_en && wb_rd != 5'd0) mem[wb_rd] <= wb_data;
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? 32'd0 : mem[rs1];
    rs2_val = (rs2 == 5'd0) ? 32'd0 : mem[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == rs1 && rs1 != 5'd0) rs1_val = wb_data;
    if (wb_en && wb_rd == rs2 && rs2 != 5'd0) rs2_val = wb_data;
`endif
  end
endmodule

// File: rtl/decode.sv
// RV32I decode stage: field decode, immediates, regfile read, wrong-path squash.
// Optional DECODE_WB_BYPASS_EN (in decode_regfile) forwards same-cycle writeback.
module decode
  import rv32i_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  decode_if.slave bus
);
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  ex_t              ex_q, ex_d;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] rs1_val, rs2_val;
  imm_fmt_t    fmt;
  alu_op_t     alu;
  logic [7:0]  ctrl;
  logic        illegal, slot_ok;

  assign opcode = bus.insn[6:0];
  assign rd     = bus.insn[11:7];
  assign funct3 = bus.insn[14:12];
  assign rs1    = bus.insn[19:15];
  assign rs2    = bus.insn[24:20];
  assign funct7 = bus.insn[31:25];
  assign alt    = (funct7 == F7_ALT);

  decode_regfile u_rf (
    .clk    (clk),
    .wb_en  (bus.wb_en),
    .wb_rd  (bus.wb_rd),
    .wb_data(bus.wb_data),
    .rs1    (rs1),
    .rs2    (rs2),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val)
  );

  function automatic alu_op_t f3_alu(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      F3_ADD_SUB: f3_alu = sub_sra ? ALU_SUB : ALU_ADD;
      F3_SLL:     f3_alu = ALU_SLL;
      F3_SLT:     f3_alu = ALU_SLT;
      F3_SLTU:    f3_alu = ALU_SLTU;
      F3_XOR:     f3_alu = ALU_XOR;
      F3_SRL_SRA: f3_alu = sub_sra ? ALU_SRA : ALU_SRL;
      F3_OR:      f3_alu = ALU_OR;
      default:    f3_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    fmt     = IMM_I;
    alu     = ALU_ADD;
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_MEM_READ]  = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
      end
      OPC_STORE: begin
        fmt = IMM_S;
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        alu = ALU_SUB;
        ctrl[CTRL_BRANCH] = 1'b1;
      end
      OPC_JAL: begin
        fmt = IMM_J;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_JAL]       = 1'b1;
      end
      OPC_JALR: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_JALR]      = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
      end
      OPC_LUI: begin
        fmt = IMM_U;
        alu = ALU_PASS_B;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
        ctrl[CTRL_USE_PC]    = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only shifts carry a real funct7; other I-types use those bits as immediate.
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) fmt = IMM_SH;
        alu = f3_alu(funct3, (funct3 == F3_SRL_SRA) && alt);
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_USE_IMM]   = 1'b1;
        if (funct3 == F3_SLL && alt) illegal = 1'b1;
      end
      OPC_OP: begin
        alu = f3_alu(funct3, alt);
        ctrl[CTRL_REG_WRITE] = 1'b1;
        if (funct7 != F7_BASE && !(alt && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)))
          illegal = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    if (rd == 5'd0) ctrl[CTRL_REG_WRITE] = 1'b0;
    if (illegal) ctrl = '0;
  end

  // Redirect reloads the count outright, discarding any partial squash.
  assign cnt_nxt = bus.pc_ex_valid ? SQ_LOAD : (cnt != '0) ? cnt - 1'b1 : cnt;
  assign slot_ok = (cnt == '0) && !bus.pc_ex_valid;

  always_comb begin
    ex_d         = '0;
    ex_d.valid   = slot_ok;
    ex_d.pc      = bus.pc_de;
    ex_d.rs1_val = rs1_val;
    ex_d.rs2_val = rs2_val;
    ex_d.imm     = gen_imm(bus.insn, fmt);
    ex_d.rd      = rd;
    ex_d.funct3  = funct3;
    ex_d.alu_op  = alu;
    ex_d.ctrl    = slot_ok ? ctrl : '0;
    ex_d.illegal = slot_ok && illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= SQ_LOAD;
      ex_q <= '0;
    end else begin
      cnt  <= cnt_nxt;
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_rs1_val = ex_q.rs1_val;
  assign bus.ex_rs2_val = ex_q.rs2_val;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_funct3  = ex_q.funct3;
  assign bus.ex_alu_op  = ex_q.alu_op;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_illegal = ex_q.illegal;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: squash timing, immediates, regfile, illegal decode, async reset.
module tb_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  decode_if bus ();

  decode #(.SQUASH_CYCLES(2), .CNT_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_valid_seq(input string tag, input int n_inv);
    for (int i = 0; i < n_inv; i++) begin
      step();
      chk(tag, 32'(bus.ex_valid), 32'd0);
    end
    step();
    chk(tag, 32'(bus.ex_valid), 32'd1);
  endtask

  initial begin
    bus.insn        = 32'h00500093;  // ADDI x1,x0,5
    bus.pc_de       = 32'h0000_0040;
    bus.pc_ex_valid = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'd0;

    step();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_imm", bus.ex_imm, 32'd0);
    chk("rst_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("rst_pc", bus.ex_pc, 32'd0);
    rst_n = 1'b1;

    chk_valid_seq("rel_valid", 2);
    chk("addi_imm", bus.ex_imm, 32'd5);
    chk("addi_rd", 32'(bus.ex_rd), 32'd1);
    chk("addi_alu", 32'(bus.ex_alu_op), 32'd0);
    chk("addi_ctrl", 32'(bus.ex_ctrl), 32'h82);
    chk("addi_pc", bus.ex_pc, 32'h40);
    chk("addi_ill", 32'(bus.ex_illegal), 32'd0);

    // Regfile: seed x3, then overwrite it in the same cycle it is read
    bus.insn = 32'h00000013;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h12345678;
    step();
    chk("nop_ctrl", 32'(bus.ex_ctrl), 32'h02);
    bus.insn = 32'h00018233;  // ADD x4,x3,x0
    bus.wb_data = 32'hDEADBEEF;
    step();
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_rs1", bus.ex_rs1_val, 32'hDEADBEEF);
`else
    chk("byp_rs1", bus.ex_rs1_val, 32'h12345678);
`endif
    chk("add_rs2", bus.ex_rs2_val, 32'd0);
    chk("add_rd", 32'(bus.ex_rd), 32'd4);
    chk("add_ctrl", 32'(bus.ex_ctrl), 32'h80);
    bus.wb_en = 1'b0;
    step();
    chk("rf_rs1", bus.ex_rs1_val, 32'hDEADBEEF);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    bus.insn = 32'h00000233;  // ADD x4,x0,x0
    step();
    chk("x0_rs1", bus.ex_rs1_val, 32'd0);
    bus.wb_en = 1'b0;

    // Single redirect pulse
    bus.insn = 32'h00500093;
    bus.pc_ex_valid = 1'b1;
    step();
    chk("redir_v0", 32'(bus.ex_valid), 32'd0);
    chk("redir_ctrl", 32'(bus.ex_ctrl), 32'd0);
    bus.pc_ex_valid = 1'b0;
    chk_valid_seq("redir_v", 2);

    // Second pulse while still squashing restarts the count
    bus.pc_ex_valid = 1'b1;
    step();
    chk("re2_v0", 32'(bus.ex_valid), 32'd0);
    bus.pc_ex_valid = 1'b0;
    step();
    chk("re2_v1", 32'(bus.ex_valid), 32'd0);
    bus.pc_ex_valid = 1'b1;
    step();
    chk("re2_p2", 32'(bus.ex_valid), 32'd0);
    bus.pc_ex_valid = 1'b0;
    chk_valid_seq("re2_v", 2);

    // Immediate formats
    bus.insn = 32'hFE000CE3; bus.pc_de = 32'h100;  // BEQ x0,x0,-8
    step();
    chk("beq_imm", bus.ex_imm, 32'hFFFFFFF8);
    chk("beq_ctrl", 32'(bus.ex_ctrl), 32'h10);
    chk("beq_f3", 32'(bus.ex_funct3), 32'd0);
    chk("beq_pc", bus.ex_pc, 32'h100);
    bus.insn = 32'h001000EF;  // JAL x1,+2048
    step();
    chk("jal_imm", bus.ex_imm, 32'h800);
    chk("jal_ctrl", 32'(bus.ex_ctrl), 32'h88);
    bus.insn = 32'h123452B7;  // LUI x5,0x12345
    step();
    chk("lui_imm", bus.ex_imm, 32'h12345000);
    chk("lui_alu", 32'(bus.ex_alu_op), 32'd10);
    chk("lui_ctrl", 32'(bus.ex_ctrl), 32'h82);
    bus.insn = 32'h00001317;  // AUIPC x6,1
    step();
    chk("auipc_imm", bus.ex_imm, 32'h1000);
    chk("auipc_ctrl", 32'(bus.ex_ctrl), 32'h83);
    bus.insn = 32'h4030D393;  // SRAI x7,x1,3
    step();
    chk("srai_imm", bus.ex_imm, 32'd3);
    chk("srai_alu", 32'(bus.ex_alu_op), 32'd7);
    chk("srai_ill", 32'(bus.ex_illegal), 32'd0);

    // Illegal decode
    bus.insn = 32'h02018233;  // OP with funct7=0x01
    step();
    chk("f7_ill", 32'(bus.ex_illegal), 32'd1);
    chk("f7_ctrl", 32'(bus.ex_ctrl), 32'd0);
    bus.insn = 32'hFFFFFFFF;
    step();
    chk("ff_ill", 32'(bus.ex_illegal), 32'd1);
    chk("ff_ctrl", 32'(bus.ex_ctrl), 32'd0);
    bus.pc_ex_valid = 1'b1;
    step();
    chk("ffsq_ill", 32'(bus.ex_illegal), 32'd0);
    chk("ffsq_ctrl", 32'(bus.ex_ctrl), 32'd0);
    bus.pc_ex_valid = 1'b0;
    step();
    chk("ffsq_ill2", 32'(bus.ex_illegal), 32'd0);
    bus.insn = 32'h00500093;
    step();
    step();
    chk("pre_arst_v", 32'(bus.ex_valid), 32'd1);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_imm", bus.ex_imm, 32'd0);
    chk("arst_rd", 32'(bus.ex_rd), 32'd0);
    chk("arst_ctrl", 32'(bus.ex_ctrl), 32'd0);
    step();
    rst_n = 1'b1;
    chk_valid_seq("arst_rel", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Second pipeline stage of the rv32i core. Consumes the registered instruction word and its PC from fetch (`insn`, `pc_de`).
- Decodes RV32I fields, generates the sign-extended immediate, reads two operands from the integrated 32x32 register file, and registers everything for execute.
- Owns wrong-path squashing after an execute redirect (`pc_ex_valid`), since fetch has no valid output or kill input.

Parameters:
- SQUASH_CYCLES, 2: number of decode-input slots discarded after reset release and after each redirect. Covers fetch's two-register latency.
- CNT_W, 2: width of the squash counter. Must satisfy 2^CNT_W > SQUASH_CYCLES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- insn  in  32  instruction from fetch
- pc_de  in  32  PC associated with insn
- pc_ex_valid  in  1  execute redirect (taken branch/jump) this cycle
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- ex_valid  out  1  execute slot holds a real instruction
- ex_pc  out  32  PC of decoded instruction
- ex_rs1_val  out  32  operand 1
- ex_rs2_val  out  32  operand 2
- ex_imm  out  32  sign-extended immediate
- ex_rd  out  5  destination register
- ex_funct3  out  3  funct3 field, passed through
- ex_alu_op  out  4  ALU operation code (package enum)
- ex_ctrl  out  8  control bits, order from package: {reg_write, mem_read, mem_write, branch, jal, jalr, use_imm, use_pc}
- ex_illegal  out  1  undecodable instruction

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0 and loads the squash counter with SQUASH_CYCLES. Register file contents are not reset.
- Latency: one cycle. Fields decoded from insn/pc_de at edge N appear on ex_* after edge N.
- Squash counter:
  - pc_ex_valid=1 loads SQUASH_CYCLES. This has priority over everything else.
  - Otherwise the counter decrements when nonzero and saturates at 0.
- ex_valid <= (cnt==0) && !pc_ex_valid. The instruction in decode during a redirect cycle is always wrong-path.
- Invalid slot: ex_ctrl and ex_illegal are forced to 0, so the slot has no side effects. Data fields are don't-care.
- Redirect while squashing: the counter reloads to the full SQUASH_CYCLES and the earlier partial count is discarded.
- Immediate formats, all sign-extended from insn[31]:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits = 0
  - J: JAL, bit0=0
- Shift-immediates: ex_imm = zero-extended shamt insn[24:20].
- LUI: alu_op=PASS_B, use_imm=1, rs1 value ignored.
- AUIPC: use_pc=1, use_imm=1, alu_op=ADD.
- rd=x0: reg_write forced 0.
- Illegal decode:
  - opcode not in the RV32I set (FENCE/SYSTEM decode as NOP with ex_illegal=0)
  - OP with funct7 not 0x00/0x20
  - funct7=0x20 on anything other than SUB/SRA/SRAI
  - illegal ⇒ ex_ctrl=0, ex_illegal=ex_valid.
- Register file:
  - Two combinational read ports, one write port written at posedge when wb_en && wb_rd!=0.
  - x0 always reads 0.
  - Writeback is accepted regardless of ex_valid and during squash.

Optional Feature:
- DECODE_WB_BYPASS_EN defined: a same-cycle write forwards to the read. If wb_en && wb_rd==rsN && rsN!=0, then ex_rsN_val <= wb_data.
- Undefined: the read returns the pre-write value. Execute must then provide the forwarding.

Decomposition:
- Package rv32i_pkg:
  - opcode localparams
  - funct3 constants
  - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B)
  - ex_ctrl bit-index constants
  - IMM_* format enum
- Sub-module regfile: 32x32, 2R1W, x0 hardwired zero, contains the bypass mux under the macro.
- decode keeps the squash counter, field decode and the output register.

Test Plan:
- Reset release with ADDI x1,x0,5 (0x00500093) held on insn → ex_valid=0 for first 2 edges, then ex_valid=1, ex_imm=5, ex_rd=1, alu_op=ADD, ex_ctrl=reg_write|use_imm.
- wb_en=1, wb_rd=3, wb_data=0xDEADBEEF, then ADD x4,x3,x0 (0x00018233) → ex_rs1_val=0xDEADBEEF, ex_rs2_val=0. Repeat in the same cycle with the macro on (0xDEADBEEF) and off (old value).
- pc_ex_valid pulse in steady state → ex_valid=0 on that edge plus 2 following edges, then 1. Second pulse mid-squash → counter restarts, 3 invalid slots total from the second pulse.
- BEQ with offset -8 (0xFE000CE3) → ex_imm=0xFFFFFFF8, ctrl=branch, funct3=0. JAL x1,+2048 (0x001000EF) → ex_imm=0x800, ctrl=jal|reg_write.
- insn=0xFFFFFFFF with valid slot → ex_illegal=1, ex_ctrl=0. Same during squash → ex_illegal=0.
- Assert rst_n low mid-stream → all ex_* read 0 immediately (before the next clk edge); squash restarts on release.
